// File: rtl/countnox_sweep.sv
// countnox_sweep: drives the CountNoX core through x = 0..LAST_X.
// For every value it runs one go/done handshake and captures the returned
// count. It emits each (value, freq) pair on a valid/ready histogram stream
// and keeps track of the mode, which is the lowest value holding the
// strictly highest count.
module countnox_sweep #(
    parameter int DATA_W    = 8,
    parameter int FREQ_W    = 8,
    parameter int LAST_X    = 255,
    parameter int SKIP_ZERO = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic [DATA_W-1:0] x,
    output logic              go,
    input  logic              done,
    input  logic [FREQ_W-1:0] freq,
    output logic              hist_valid,
    input  logic              hist_ready,
    output logic [DATA_W-1:0] hist_value,
    output logic [FREQ_W-1:0] hist_freq,
    output logic [DATA_W-1:0] mode_value,
    output logic [FREQ_W-1:0] mode_freq,
    output logic              sweep_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_EMIT,
        S_RELEASE,
        S_FINISH
    } state_t;

    localparam logic [DATA_W-1:0] LAST_V = DATA_W'(LAST_X);

    state_t            state_q;
    logic              busy_q;
    logic [DATA_W-1:0] x_q;
    logic              go_q;
    logic              hist_valid_q;
    logic [DATA_W-1:0] hist_value_q;
    logic [FREQ_W-1:0] hist_freq_q;
    logic [DATA_W-1:0] mode_value_q;
    logic [FREQ_W-1:0] mode_freq_q;
    logic              sweep_done_q;

    logic [DATA_W-1:0] x_d;
    logic              at_last;
    logic              mode_take;
    logic              drop_entry;

    // Next search value, end-of-sweep test, mode update and zero-skip decisions
    assign x_d        = x_q + 1'b1;
    assign at_last    = (x_q == LAST_V);
    assign mode_take  = (freq > mode_freq_q);
    assign drop_entry = (SKIP_ZERO != 0) && (freq == '0);

    // Sweep sequencer: all outputs are registered and change only on state transitions
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            busy_q       <= 1'b0;
            x_q          <= '0;
            go_q         <= 1'b0;
            hist_valid_q <= 1'b0;
            hist_value_q <= '0;
            hist_freq_q  <= '0;
            mode_value_q <= '0;
            mode_freq_q  <= '0;
            sweep_done_q <= 1'b0;
        end else begin
            sweep_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q      <= S_ISSUE;
                        busy_q       <= 1'b1;
                        x_q          <= '0;
                        go_q         <= 1'b1;
                        mode_value_q <= '0;
                        mode_freq_q  <= '0;
                    end
                end
                S_ISSUE: begin
                    if (done) begin
                        hist_value_q <= x_q;
                        hist_freq_q  <= freq;
                        go_q         <= 1'b0;
                        // Strict compare keeps the earliest (lowest) value on ties
                        if (mode_take) begin
                            mode_value_q <= x_q;
                            mode_freq_q  <= freq;
                        end
                        if (drop_entry) begin
                            state_q <= S_RELEASE;
                        end else begin
                            state_q      <= S_EMIT;
                            hist_valid_q <= 1'b1;
                        end
                    end
                end
                S_EMIT: begin
                    // Downstream backpressure may stall here indefinitely; go is already low
                    if (hist_ready) begin
                        hist_valid_q <= 1'b0;
                        state_q      <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    // The core must drop done before the next request is raised
                    if (!done) begin
                        if (at_last) begin
                            state_q      <= S_FINISH;
                            sweep_done_q <= 1'b1;
                            busy_q       <= 1'b0;
                        end else begin
                            x_q     <= x_d;
                            go_q    <= 1'b1;
                            state_q <= S_ISSUE;
                        end
                    end
                end
                S_FINISH: begin
                    // start is deliberately not looked at in this cycle
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign x          = x_q;
    assign go         = go_q;
    assign hist_valid = hist_valid_q;
    assign hist_value = hist_value_q;
    assign hist_freq  = hist_freq_q;
    assign mode_value = mode_value_q;
    assign mode_freq  = mode_freq_q;
    assign sweep_done = sweep_done_q;

endmodule

// File: tb/tb_countnox_sweep.sv
// Testbench for countnox_sweep. It builds three instances:
//   0: LAST_X=255, SKIP_ZERO=0
//   1: LAST_X=255, SKIP_ZERO=1
//   2: LAST_X=3,   SKIP_ZERO=0
// Each instance is paired with a table-driven counting core model.
module tb_countnox_sweep;

    localparam int NI   = 3;
    localparam int MAXE = 2048;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start_r [NI];
    logic       ready_r [NI];
    logic       done_r  [NI];
    logic [7:0] freq_r  [NI];
    logic       busy_w  [NI];
    logic       go_w    [NI];
    logic       hv_w    [NI];
    logic       sd_w    [NI];
    logic [7:0] x_w     [NI];
    logic [7:0] hval_w  [NI];
    logic [7:0] hfreq_w [NI];
    logic [7:0] mval_w  [NI];
    logic [7:0] mfreq_w [NI];

    logic [7:0] tab [NI][256];
    int         cnt [NI];

    int tests_run    = 0;
    int tests_failed = 0;

    // Monitor state, written only by the monitor process
    int         rx_cnt   [NI] = '{default: 0};
    logic [7:0] rx_val   [NI][MAXE];
    logic [7:0] rx_freq  [NI][MAXE];
    int         sd_cnt   [NI] = '{default: 0};
    int         ovl_cnt  [NI] = '{default: 0};
    int         xov_cnt  [NI] = '{default: 0};
    int         xchg_cnt [NI] = '{default: 0};
    logic       prev_go  [NI] = '{default: 1'b0};
    logic [7:0] prev_x   [NI] = '{default: 8'd0};

    // Expected sweep result from the reference model
    logic [7:0] exp_val  [MAXE];
    logic [7:0] exp_freq [MAXE];
    int         exp_cnt;
    logic [7:0] exp_mv;
    logic [7:0] exp_mf;

    function automatic int last_of(input int i);
        return (i == 2) ? 3 : 255;
    endfunction

    function automatic bit skip_of(input int i);
        return (i == 1);
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < NI; gi++) begin : g_inst
            countnox_sweep #(
                .DATA_W   (8),
                .FREQ_W   (8),
                .LAST_X   ((gi == 2) ? 3 : 255),
                .SKIP_ZERO((gi == 1) ? 1 : 0)
            ) u_dut (
                .clk       (clk),
                .reset     (rst_n),
                .start     (start_r[gi]),
                .busy      (busy_w[gi]),
                .x         (x_w[gi]),
                .go        (go_w[gi]),
                .done      (done_r[gi]),
                .freq      (freq_r[gi]),
                .hist_valid(hv_w[gi]),
                .hist_ready(ready_r[gi]),
                .hist_value(hval_w[gi]),
                .hist_freq (hfreq_w[gi]),
                .mode_value(mval_w[gi]),
                .mode_freq (mfreq_w[gi]),
                .sweep_done(sd_w[gi])
            );
        end
    endgenerate

    // Core model: done rises 3 cycles after go, freq comes from the table and is
    // noise while done is low, and done drops one cycle after go drops
    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (!go_w[i]) begin
                cnt[i]    <= 0;
                done_r[i] <= 1'b0;
                freq_r[i] <= 8'($urandom);
            end else if (!done_r[i]) begin
                if (cnt[i] == 2) begin
                    done_r[i] <= 1'b1;
                    freq_r[i] <= tab[i][x_w[i]];
                end else begin
                    cnt[i] <= cnt[i] + 1;
                end
            end
        end
    end

    // Monitor: record accepted entries, count sweep_done pulses and protocol violations
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (hv_w[i] && ready_r[i]) begin
                if (rx_cnt[i] < MAXE) begin
                    rx_val[i][rx_cnt[i]]  = hval_w[i];
                    rx_freq[i][rx_cnt[i]] = hfreq_w[i];
                end
                rx_cnt[i] = rx_cnt[i] + 1;
            end
            if (sd_w[i]) sd_cnt[i] = sd_cnt[i] + 1;
            if (go_w[i] && hv_w[i]) ovl_cnt[i] = ovl_cnt[i] + 1;
            if (int'(x_w[i]) > last_of(i)) xov_cnt[i] = xov_cnt[i] + 1;
            if (go_w[i] && prev_go[i] && (x_w[i] != prev_x[i])) xchg_cnt[i] = xchg_cnt[i] + 1;
            prev_go[i] = go_w[i];
            prev_x[i]  = x_w[i];
        end
    end

    // Reference model: walk the table in order, drop zeros when skipping,
    // and keep the first value that reaches the maximum count
    task automatic build_model(input int idx);
        exp_cnt = 0;
        exp_mv  = 8'd0;
        exp_mf  = 8'd0;
        for (int v = 0; v <= last_of(idx); v++) begin
            if (!(skip_of(idx) && tab[idx][v] == 8'd0)) begin
                exp_val[exp_cnt]  = 8'(v);
                exp_freq[exp_cnt] = tab[idx][v];
                exp_cnt++;
            end
            if (tab[idx][v] > exp_mf) begin
                exp_mf = tab[idx][v];
                exp_mv = 8'(v);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int idx);
        start_r[idx] = 1'b1;
        tick();
        start_r[idx] = 1'b0;
    endtask

    // Run until sweep_done is seen; ok=0 if the cycle budget runs out
    task automatic wait_sweep(input int idx, input bit rnd_ready, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 20000; c++) begin
            if (sd_w[idx]) begin
                ok = 1'b1;
                break;
            end
            if (rnd_ready) ready_r[idx] = 1'($urandom_range(0, 1));
            tick();
        end
        ready_r[idx] = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        for (int i = 0; i < NI; i++) begin
            tests_run++;
            if ({busy_w[i], go_w[i], hv_w[i], sd_w[i], x_w[i], hval_w[i], hfreq_w[i], mval_w[i], mfreq_w[i]} !== 44'd0) begin
                tests_failed++;
                $display("FAIL reset_outputs[%0d]: busy=%0b go=%0b hv=%0b sd=%0b x=%0d hval=%0d hfreq=%0d mode=(%0d,%0d), required all 0",
                         i, busy_w[i], go_w[i], hv_w[i], sd_w[i], x_w[i], hval_w[i], hfreq_w[i], mval_w[i], mfreq_w[i]);
            end
        end
        rst_n = 1'b1;
        tick();
        $display("[TB] reset: outputs checked on %0d instances", NI);
    endtask

    task automatic test_mod4();
        int base, sd0, ovl0, got;
        bit ok;
        for (int v = 0; v < 256; v++) tab[0][v] = 8'(v % 4);
        build_model(0);
        base = rx_cnt[0]; sd0 = sd_cnt[0]; ovl0 = ovl_cnt[0];
        ready_r[0] = 1'b1;
        pulse_start(0);
        tests_run++;
        if ({busy_w[0], go_w[0], x_w[0]} !== {1'b1, 1'b1, 8'd0}) begin
            tests_failed++;
            $display("FAIL mod4_accept: busy=%0b go=%0b x=%0d, required busy=1 go=1 x=0", busy_w[0], go_w[0], x_w[0]);
        end
        wait_sweep(0, 1'b0, ok);
        tests_run++;
        if (!ok) begin tests_failed++; $display("FAIL mod4_timeout: sweep_done=0, required 1"); end
        tick();
        tests_run++;
        if (busy_w[0] !== 1'b0 || (sd_cnt[0] - sd0) != 1) begin
            tests_failed++;
            $display("FAIL mod4_finish: busy=%0b sweep_done pulses=%0d, required busy=0 pulses=1", busy_w[0], sd_cnt[0] - sd0);
        end
        got = rx_cnt[0] - base;
        tests_run++;
        if (got != 256) begin tests_failed++; $display("FAIL mod4_count: got %0d entries, required 256", got); end
        for (int k = 0; k < exp_cnt && k < got && base + k < MAXE; k++) begin
            tests_run++;
            if ({rx_val[0][base+k], rx_freq[0][base+k]} !== {exp_val[k], exp_freq[k]}) begin
                tests_failed++;
                $display("FAIL mod4_entry[%0d]: got (%0d,%0d), required (%0d,%0d)", k, rx_val[0][base+k], rx_freq[0][base+k], exp_val[k], exp_freq[k]);
            end
        end
        tests_run++;
        if ({mval_w[0], mfreq_w[0]} !== {8'd3, 8'd3}) begin
            tests_failed++;
            $display("FAIL mod4_mode: got (%0d,%0d), required (3,3)", mval_w[0], mfreq_w[0]);
        end
        tests_run++;
        if (ovl_cnt[0] != ovl0) begin tests_failed++; $display("FAIL mod4_valid_with_go: %0d cycles, required 0", ovl_cnt[0] - ovl0); end
        $display("[TB] mod4: %0d entries, mode (%0d,%0d)", got, mval_w[0], mfreq_w[0]);
    endtask

    task automatic test_tie();
        int base, got;
        bit ok;
        for (int v = 0; v < 256; v++) tab[0][v] = 8'd1;
        tab[0][10] = 8'd9;
        tab[0][20] = 8'd9;
        build_model(0);
        base = rx_cnt[0];
        pulse_start(0);
        wait_sweep(0, 1'b1, ok);
        tests_run++;
        if (!ok) begin tests_failed++; $display("FAIL tie_timeout: sweep_done=0, required 1"); end
        tick();
        got = rx_cnt[0] - base;
        tests_run++;
        if (got != exp_cnt) begin tests_failed++; $display("FAIL tie_count: got %0d entries, required %0d", got, exp_cnt); end
        for (int k = 0; k < exp_cnt && k < got && base + k < MAXE; k++) begin
            tests_run++;
            if ({rx_val[0][base+k], rx_freq[0][base+k]} !== {exp_val[k], exp_freq[k]}) begin
                tests_failed++;
                $display("FAIL tie_entry[%0d]: got (%0d,%0d), required (%0d,%0d)", k, rx_val[0][base+k], rx_freq[0][base+k], exp_val[k], exp_freq[k]);
            end
        end
        tests_run++;
        if ({mval_w[0], mfreq_w[0]} !== {8'd10, 8'd9}) begin
            tests_failed++;
            $display("FAIL tie_mode: got (%0d,%0d), required (10,9)", mval_w[0], mfreq_w[0]);
        end
        $display("[TB] tie: mode (%0d,%0d)", mval_w[0], mfreq_w[0]);
    endtask

    task automatic test_backpressure();
        int base, got;
        bit ok, stalled, seen8;
        for (int v = 0; v < 256; v++) tab[0][v] = 8'($urandom);
        build_model(0);
        base = rx_cnt[0];
        stalled = 1'b0;
        ok = 1'b0;
        pulse_start(0);
        for (int c = 0; c < 30000; c++) begin
            if (sd_w[0]) begin ok = 1'b1; break; end
            if (!stalled && hv_w[0] && hval_w[0] == 8'd7) begin
                ready_r[0] = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    tick();
                    tests_run++;
                    if ({hv_w[0], hval_w[0], hfreq_w[0], go_w[0], x_w[0]} !== {1'b1, 8'd7, tab[0][7], 1'b0, 8'd7}) begin
                        tests_failed++;
                        $display("FAIL bp_hold[%0d]: hv=%0b hval=%0d hfreq=%0d go=%0b x=%0d, required hv=1 hval=7 hfreq=%0d go=0 x=7",
                                 s, hv_w[0], hval_w[0], hfreq_w[0], go_w[0], x_w[0], tab[0][7]);
                    end
                end
                ready_r[0] = 1'b1;
                tick();
                tests_run++;
                if ({hv_w[0], go_w[0], x_w[0]} !== {1'b0, 1'b0, 8'd7}) begin
                    tests_failed++;
                    $display("FAIL bp_accept: hv=%0b go=%0b x=%0d, required hv=0 go=0 x=7", hv_w[0], go_w[0], x_w[0]);
                end
                seen8 = 1'b0;
                for (int w = 0; w < 20; w++) begin
                    tick();
                    if (go_w[0]) begin seen8 = (x_w[0] == 8'd8); break; end
                end
                tests_run++;
                if (!seen8) begin tests_failed++; $display("FAIL bp_next_issue: go=%0b x=%0d, required go=1 x=8", go_w[0], x_w[0]); end
                stalled = 1'b1;
            end else begin
                ready_r[0] = 1'($urandom_range(0, 1));
                tick();
            end
        end
        ready_r[0] = 1'b1;
        tests_run++;
        if (!ok || !stalled) begin tests_failed++; $display("FAIL bp_timeout: done=%0b stalled=%0b, required 1 1", ok, stalled); end
        tick();
        got = rx_cnt[0] - base;
        tests_run++;
        if (got != exp_cnt) begin tests_failed++; $display("FAIL bp_count: got %0d entries, required %0d", got, exp_cnt); end
        for (int k = 0; k < exp_cnt && k < got && base + k < MAXE; k++) begin
            tests_run++;
            if ({rx_val[0][base+k], rx_freq[0][base+k]} !== {exp_val[k], exp_freq[k]}) begin
                tests_failed++;
                $display("FAIL bp_entry[%0d]: got (%0d,%0d), required (%0d,%0d)", k, rx_val[0][base+k], rx_freq[0][base+k], exp_val[k], exp_freq[k]);
            end
        end
        tests_run++;
        if ({mval_w[0], mfreq_w[0]} !== {exp_mv, exp_mf}) begin
            tests_failed++;
            $display("FAIL bp_mode: got (%0d,%0d), required (%0d,%0d)", mval_w[0], mfreq_w[0], exp_mv, exp_mf);
        end
        $display("[TB] backpressure: %0d entries, mode (%0d,%0d)", got, mval_w[0], mfreq_w[0]);
    endtask

    task automatic test_skip_zero();
        int base, got;
        bit ok;
        for (int v = 0; v < 256; v++) tab[1][v] = 8'd0;
        tab[1][5]   = 8'd3;
        tab[1][200] = 8'd3;
        base = rx_cnt[1];
        pulse_start(1);
        wait_sweep(1, 1'b0, ok);
        tests_run++;
        if (!ok) begin tests_failed++; $display("FAIL skip_timeout: sweep_done=0, required 1"); end
        tick();
        got = rx_cnt[1] - base;
        tests_run++;
        if (got != 2) begin tests_failed++; $display("FAIL skip_count: got %0d entries, required 2", got); end
        tests_run++;
        if (got >= 2 && {rx_val[1][base], rx_freq[1][base], rx_val[1][base+1], rx_freq[1][base+1]} !== {8'd5, 8'd3, 8'd200, 8'd3}) begin
            tests_failed++;
            $display("FAIL skip_entries: got (%0d,%0d) (%0d,%0d), required (5,3) (200,3)",
                     rx_val[1][base], rx_freq[1][base], rx_val[1][base+1], rx_freq[1][base+1]);
        end
        tests_run++;
        if ({mval_w[1], mfreq_w[1]} !== {8'd5, 8'd3}) begin
            tests_failed++;
            $display("FAIL skip_mode: got (%0d,%0d), required (5,3)", mval_w[1], mfreq_w[1]);
        end
        $display("[TB] skip_zero: %0d entries, mode (%0d,%0d)", got, mval_w[1], mfreq_w[1]);

        // Sparse random table with random backpressure
        for (int v = 0; v < 256; v++) tab[1][v] = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'd0;
        build_model(1);
        base = rx_cnt[1];
        tick();
        pulse_start(1);
        wait_sweep(1, 1'b1, ok);
        tests_run++;
        if (!ok) begin tests_failed++; $display("FAIL skiprnd_timeout: sweep_done=0, required 1"); end
        tick();
        got = rx_cnt[1] - base;
        tests_run++;
        if (got != exp_cnt) begin tests_failed++; $display("FAIL skiprnd_count: got %0d entries, required %0d", got, exp_cnt); end
        for (int k = 0; k < exp_cnt && k < got && base + k < MAXE; k++) begin
            tests_run++;
            if ({rx_val[1][base+k], rx_freq[1][base+k]} !== {exp_val[k], exp_freq[k]}) begin
                tests_failed++;
                $display("FAIL skiprnd_entry[%0d]: got (%0d,%0d), required (%0d,%0d)", k, rx_val[1][base+k], rx_freq[1][base+k], exp_val[k], exp_freq[k]);
            end
        end
        tests_run++;
        if ({mval_w[1], mfreq_w[1]} !== {exp_mv, exp_mf}) begin
            tests_failed++;
            $display("FAIL skiprnd_mode: got (%0d,%0d), required (%0d,%0d)", mval_w[1], mfreq_w[1], exp_mv, exp_mf);
        end
        $display("[TB] skip_zero random: %0d entries, mode (%0d,%0d)", got, mval_w[1], mfreq_w[1]);
    endtask

    task automatic test_reset_mid();
        int base, got;
        bit ok, hit;
        for (int v = 0; v < 256; v++) tab[0][v] = 8'($urandom_range(1, 255));
        hit = 1'b0;
        pulse_start(0);
        for (int c = 0; c < 5000; c++) begin
            if (go_w[0] && x_w[0] == 8'd40) begin hit = 1'b1; break; end
            tick();
        end
        tests_run++;
        if (!hit) begin tests_failed++; $display("FAIL rstmid_reach40: x=%0d go=%0b, required x=40 go=1", x_w[0], go_w[0]); end
        rst_n = 1'b0;
        tick();
        tests_run++;
        if (go_w[0] !== 1'b0) begin tests_failed++; $display("FAIL rstmid_go: got %0b, required 0", go_w[0]); end
        tests_run++;
        if (busy_w[0] !== 1'b0) begin tests_failed++; $display("FAIL rstmid_busy: got %0b, required 0", busy_w[0]); end
        tests_run++;
        if (hv_w[0] !== 1'b0) begin tests_failed++; $display("FAIL rstmid_valid: got %0b, required 0", hv_w[0]); end
        tests_run++;
        if (x_w[0] !== 8'd0) begin tests_failed++; $display("FAIL rstmid_x: got %0d, required 0", x_w[0]); end
        tests_run++;
        if ({mval_w[0], mfreq_w[0]} !== 16'd0) begin tests_failed++; $display("FAIL rstmid_mode: got (%0d,%0d), required (0,0)", mval_w[0], mfreq_w[0]); end
        tick();
        rst_n = 1'b1;
        base = rx_cnt[0];
        for (int c = 0; c < 20; c++) tick();
        tests_run++;
        if (rx_cnt[0] != base || busy_w[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL rstmid_quiet: %0d entries busy=%0b after reset, required 0 entries busy=0", rx_cnt[0] - base, busy_w[0]);
        end
        for (int v = 0; v < 256; v++) tab[0][v] = 8'($urandom_range(0, 60));
        build_model(0);
        base = rx_cnt[0];
        pulse_start(0);
        wait_sweep(0, 1'b1, ok);
        tests_run++;
        if (!ok) begin tests_failed++; $display("FAIL rstmid_timeout: sweep_done=0, required 1"); end
        tick();
        got = rx_cnt[0] - base;
        tests_run++;
        if (got != exp_cnt) begin tests_failed++; $display("FAIL rstmid_count: got %0d entries, required %0d", got, exp_cnt); end
        for (int k = 0; k < exp_cnt && k < got && base + k < MAXE; k++) begin
            tests_run++;
            if ({rx_val[0][base+k], rx_freq[0][base+k]} !== {exp_val[k], exp_freq[k]}) begin
                tests_failed++;
                $display("FAIL rstmid_entry[%0d]: got (%0d,%0d), required (%0d,%0d)", k, rx_val[0][base+k], rx_freq[0][base+k], exp_val[k], exp_freq[k]);
            end
        end
        tests_run++;
        if ({mval_w[0], mfreq_w[0]} !== {exp_mv, exp_mf}) begin
            tests_failed++;
            $display("FAIL rstmid_mode: got (%0d,%0d), required (%0d,%0d)", mval_w[0], mfreq_w[0], exp_mv, exp_mf);
        end
        $display("[TB] reset mid-sweep: restart produced %0d entries, mode (%0d,%0d)", got, mval_w[0], mfreq_w[0]);
    endtask

    task automatic test_start_busy();
        int base, sd0, got;
        bit ok;
        for (int v = 0; v < 4; v++) tab[2][v] = 8'($urandom);
        build_model(2);
        base = rx_cnt[2]; sd0 = sd_cnt[2];
        pulse_start(2);
        for (int c = 0; c < 5; c++) tick();
        pulse_start(2);
        wait_sweep(2, 1'b1, ok);
        tests_run++;
        if (!ok) begin tests_failed++; $display("FAIL busy_timeout: sweep_done=0, required 1"); end
        // start raised during the FINISH cycle must be ignored
        start_r[2] = 1'b1;
        tick();
        start_r[2] = 1'b0;
        for (int c = 0; c < 6; c++) tick();
        tests_run++;
        if ({busy_w[2], go_w[2]} !== 2'b00) begin
            tests_failed++;
            $display("FAIL busy_finish_start: busy=%0b go=%0b, required 0 0", busy_w[2], go_w[2]);
        end
        tests_run++;
        if ((sd_cnt[2] - sd0) != 1) begin tests_failed++; $display("FAIL busy_pulses: got %0d sweep_done pulses, required 1", sd_cnt[2] - sd0); end
        got = rx_cnt[2] - base;
        tests_run++;
        if (got != 4) begin tests_failed++; $display("FAIL busy_count: got %0d entries, required 4", got); end
        for (int k = 0; k < exp_cnt && k < got && base + k < MAXE; k++) begin
            tests_run++;
            if ({rx_val[2][base+k], rx_freq[2][base+k]} !== {exp_val[k], exp_freq[k]}) begin
                tests_failed++;
                $display("FAIL busy_entry[%0d]: got (%0d,%0d), required (%0d,%0d)", k, rx_val[2][base+k], rx_freq[2][base+k], exp_val[k], exp_freq[k]);
            end
        end
        tests_run++;
        if ({mval_w[2], mfreq_w[2]} !== {exp_mv, exp_mf}) begin
            tests_failed++;
            $display("FAIL busy_mode: got (%0d,%0d), required (%0d,%0d)", mval_w[2], mfreq_w[2], exp_mv, exp_mf);
        end
        $display("[TB] start while busy: %0d entries, %0d pulses", got, sd_cnt[2] - sd0);
    endtask

    task automatic test_back_to_back();
        int base, got;
        bit ok;
        for (int v = 0; v < 4; v++) tab[2][v] = 8'($urandom_range(200, 255));
        pulse_start(2);
        wait_sweep(2, 1'b0, ok);
        tests_run++;
        if (!ok) begin tests_failed++; $display("FAIL b2b_first_timeout: sweep_done=0, required 1"); end
        tick();
        for (int v = 0; v < 4; v++) tab[2][v] = 8'($urandom_range(0, 50));
        build_model(2);
        base = rx_cnt[2];
        pulse_start(2);
        tests_run++;
        if ({busy_w[2], x_w[2], mval_w[2], mfreq_w[2]} !== 25'h1_00_00_00) begin
            tests_failed++;
            $display("FAIL b2b_restart: busy=%0b x=%0d mode=(%0d,%0d), required busy=1 x=0 mode=(0,0)", busy_w[2], x_w[2], mval_w[2], mfreq_w[2]);
        end
        wait_sweep(2, 1'b1, ok);
        tests_run++;
        if (!ok) begin tests_failed++; $display("FAIL b2b_second_timeout: sweep_done=0, required 1"); end
        tick();
        got = rx_cnt[2] - base;
        tests_run++;
        if (got != exp_cnt) begin tests_failed++; $display("FAIL b2b_count: got %0d entries, required %0d", got, exp_cnt); end
        for (int k = 0; k < exp_cnt && k < got && base + k < MAXE; k++) begin
            tests_run++;
            if ({rx_val[2][base+k], rx_freq[2][base+k]} !== {exp_val[k], exp_freq[k]}) begin
                tests_failed++;
                $display("FAIL b2b_entry[%0d]: got (%0d,%0d), required (%0d,%0d)", k, rx_val[2][base+k], rx_freq[2][base+k], exp_val[k], exp_freq[k]);
            end
        end
        tests_run++;
        if ({mval_w[2], mfreq_w[2]} !== {exp_mv, exp_mf}) begin
            tests_failed++;
            $display("FAIL b2b_mode: got (%0d,%0d), required (%0d,%0d)", mval_w[2], mfreq_w[2], exp_mv, exp_mf);
        end
        $display("[TB] back-to-back: second sweep mode (%0d,%0d)", mval_w[2], mfreq_w[2]);
    endtask

    task automatic test_invariants();
        for (int i = 0; i < NI; i++) begin
            tests_run++;
            if (ovl_cnt[i] != 0) begin tests_failed++; $display("FAIL inv_valid_with_go[%0d]: %0d cycles, required 0", i, ovl_cnt[i]); end
            tests_run++;
            if (xov_cnt[i] != 0) begin tests_failed++; $display("FAIL inv_x_range[%0d]: %0d cycles past LAST_X, required 0", i, xov_cnt[i]); end
            tests_run++;
            if (xchg_cnt[i] != 0) begin tests_failed++; $display("FAIL inv_x_stable[%0d]: %0d changes while go, required 0", i, xchg_cnt[i]); end
        end
        $display("[TB] invariants: checked on %0d instances", NI);
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < NI; i++) begin
            start_r[i] = 1'b0;
            ready_r[i] = 1'b1;
            for (int v = 0; v < 256; v++) tab[i][v] = 8'd0;
        end
        test_reset();
        test_mod4();
        test_tie();
        test_backpressure();
        test_skip_zero();
        test_reset_mid();
        test_start_busy();
        test_back_to_back();
        test_invariants();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
